// File: rtl/gray_counter_param_if.sv
// Control and status bundle for the parametrised Gray counter.
// The master drives the controls; the slave is the counter itself.
interface gray_counter_param_if #(
  parameter int unsigned WIDTH = 4
);
  logic             en;
  logic             up_dn;
  logic             load;
  logic [WIDTH-1:0] load_gray;
  logic [WIDTH-1:0] count;
  logic [WIDTH-1:0] bin;
  logic             tc;
  logic             wrap;

  modport master (
    output en,
    output up_dn,
    output load,
    output load_gray,
    input  count,
    input  bin,
    input  tc,
    input  wrap
  );

  modport slave (
    input  en,
    input  up_dn,
    input  load,
    input  load_gray,
    output count,
    output bin,
    output tc,
    output wrap
  );
endinterface

// File: rtl/gray_counter_param.sv
// Up/down Gray counter with load, wrap/saturate mode,
// terminal count and a registered wrap pulse.
module gray_counter_param #(
  parameter int unsigned WIDTH    = 4,
  parameter bit          SATURATE = 1'b0,
  parameter int unsigned RST_BIN  = 0
) (
  input  logic                clk,
  input  logic                rst,
  gray_counter_param_if.slave io
);

  localparam logic [WIDTH-1:0] RST_B = WIDTH'(RST_BIN);
  localparam logic [WIDTH-1:0] RST_G = RST_B ^ (RST_B >> 1);
  localparam logic [WIDTH-1:0] MAX   = '1;
  localparam logic [WIDTH-1:0] ZERO  = '0;
  localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);

  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] gray_q, gray_d;
  logic             wrap_q, wrap_d;
  logic [WIDTH-1:0] load_bin;
  logic             at_end;
  logic             tc;

  // Bit i of the binary value is the XOR of all Gray bits at or above i.
  always_comb begin
    load_bin = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      load_bin[i] = ^(io.load_gray >> i);
    end
  end

  always_comb begin
    at_end = io.up_dn ? (b_q == MAX)
                      : (b_q == ZERO);
    tc = io.en & ~io.load & at_end;
  end

  always_comb begin
    b_d    = b_q;
    wrap_d = 1'b0;
    unique case (1'b1)
      io.load: begin
        b_d = load_bin;
      end
      (~io.load & io.en): begin
        if (tc && SATURATE) begin
          b_d = b_q;
        end else if (io.up_dn) begin
          b_d = b_q + ONE;
        end else begin
          b_d = b_q - ONE;
        end
        wrap_d = tc & ~SATURATE;
      end
      default: begin
        b_d = b_q;
      end
    endcase
    gray_d = b_d ^ (b_d >> 1);
  end

  // Gray and binary views share one edge so they never disagree.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      b_q    <= RST_B;
      gray_q <= RST_G;
      wrap_q <= 1'b0;
    end else begin
      b_q    <= b_d;
      gray_q <= gray_d;
      wrap_q <= wrap_d;
    end
  end

  assign io.count = gray_q;
  assign io.bin   = b_q;
  assign io.tc    = tc;
  assign io.wrap  = wrap_q;

endmodule

// File: tb/tb_gray_counter_param.sv
// Directed vector bench for gray_counter_param: a wrapping
// instance and a saturating instance share clock and reset.
module tb_gray_counter_param;

  logic clk;
  logic rst;

  gray_counter_param_if #(.WIDTH(4)) ifa ();
  gray_counter_param_if #(.WIDTH(4)) ifb ();

  gray_counter_param #(
    .WIDTH(4), .SATURATE(1'b0), .RST_BIN(0)
  ) u_wrap (
    .clk(clk), .rst(rst), .io(ifa)
  );

  gray_counter_param #(
    .WIDTH(4), .SATURATE(1'b1), .RST_BIN(0)
  ) u_sat (
    .clk(clk), .rst(rst), .io(ifb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit         sel;
    logic       en;
    logic       up;
    logic       ld;
    logic [3:0] lg;
    logic       tc;
    logic [3:0] cnt;
    logic [3:0] bin;
    logic       wrap;
  } vec_t;

  vec_t seq1[$];
  vec_t seq2[$];

  int n_vec;
  int n_cmp;
  int n_bad;

  function automatic vec_t mk(
    bit s, logic e, logic u, logic l,
    logic [3:0] g, logic t,
    logic [3:0] c, logic [3:0] b, logic w
  );
    vec_t v;
    v.sel = s; v.en = e; v.up = u;
    v.ld = l; v.lg = g; v.tc = t;
    v.cnt = c; v.bin = b; v.wrap = w;
    return v;
  endfunction

  task automatic chk(
    string name, logic [31:0] act, logic [31:0] exp
  );
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h",
               name, act, exp);
    end
  endtask

  task automatic idle_all();
    ifa.en = 0; ifa.up_dn = 1; ifa.load = 0;
    ifa.load_gray = '0;
    ifb.en = 0; ifb.up_dn = 1; ifb.load = 0;
    ifb.load_gray = '0;
  endtask

  task automatic apply(vec_t v, int idx);
    logic [3:0] prev;
    logic [3:0] c;
    idle_all();
    if (v.sel) begin
      ifb.en = v.en; ifb.up_dn = v.up;
      ifb.load = v.ld; ifb.load_gray = v.lg;
    end else begin
      ifa.en = v.en; ifa.up_dn = v.up;
      ifa.load = v.ld; ifa.load_gray = v.lg;
    end
    n_vec++;
    #1;
    prev = v.sel ? ifb.count : ifa.count;
    chk($sformatf("v%0d tc", idx),
        32'(v.sel ? ifb.tc : ifa.tc), 32'(v.tc));
    @(posedge clk);
    #1;
    c = v.sel ? ifb.count : ifa.count;
    chk($sformatf("v%0d count", idx), 32'(c), 32'(v.cnt));
    chk($sformatf("v%0d bin", idx),
        32'(v.sel ? ifb.bin : ifa.bin), 32'(v.bin));
    chk($sformatf("v%0d wrap", idx),
        32'(v.sel ? ifb.wrap : ifa.wrap), 32'(v.wrap));
    if (!v.ld && c != prev) begin
      chk($sformatf("v%0d onebit", idx),
          32'($countones(c ^ prev)), 32'd1);
    end
  endtask

  initial begin
    n_vec = 0; n_cmp = 0; n_bad = 0;

    // Up count through the wrap point, then down from zero.
    seq1.push_back(mk(0,1,1,0,0,0,4'b0001, 1,0));
    seq1.push_back(mk(0,1,1,0,0,0,4'b0011, 2,0));
    seq1.push_back(mk(0,1,1,0,0,0,4'b0010, 3,0));
    seq1.push_back(mk(0,1,1,0,0,0,4'b0110, 4,0));
    seq1.push_back(mk(0,1,1,0,0,0,4'b0111, 5,0));
    seq1.push_back(mk(0,1,1,0,0,0,4'b0101, 6,0));
    seq1.push_back(mk(0,1,1,0,0,0,4'b0100, 7,0));
    seq1.push_back(mk(0,1,1,0,0,0,4'b1100, 8,0));
    seq1.push_back(mk(0,1,1,0,0,0,4'b1101, 9,0));
    seq1.push_back(mk(0,1,1,0,0,0,4'b1111,10,0));
    seq1.push_back(mk(0,1,1,0,0,0,4'b1110,11,0));
    seq1.push_back(mk(0,1,1,0,0,0,4'b1010,12,0));
    seq1.push_back(mk(0,1,1,0,0,0,4'b1011,13,0));
    seq1.push_back(mk(0,1,1,0,0,0,4'b1001,14,0));
    seq1.push_back(mk(0,1,1,0,0,0,4'b1000,15,0));
    seq1.push_back(mk(0,1,1,0,0,1,4'b0000, 0,1));
    seq1.push_back(mk(0,1,0,0,0,1,4'b1000,15,1));
    seq1.push_back(mk(0,1,0,0,0,0,4'b1001,14,0));
    seq1.push_back(mk(0,1,0,0,0,0,4'b1011,13,0));
    seq1.push_back(mk(0,1,1,1,4'b0110,0,4'b0110,4,0));
    seq1.push_back(mk(0,1,1,0,0,0,4'b0111, 5,0));
    seq1.push_back(mk(0,1,1,0,0,0,4'b0101, 6,0));

    // Resume after reset, hold, load-vs-tc, saturate mode.
    seq2.push_back(mk(0,1,1,0,0,0,4'b0001, 1,0));
    seq2.push_back(mk(0,1,1,0,0,0,4'b0011, 2,0));
    for (int k = 0; k < 5; k++) begin
      seq2.push_back(mk(0,0,k[0],0,0,0,4'b0011,2,0));
    end
    seq2.push_back(mk(0,1,0,1,4'b1000,0,4'b1000,15,0));
    seq2.push_back(mk(0,1,1,1,4'b0000,0,4'b0000, 0,0));
    seq2.push_back(mk(0,1,0,0,0,1,4'b1000,15,1));
    seq2.push_back(mk(0,0,0,0,0,0,4'b1000,15,0));
    seq2.push_back(mk(0,1,1,0,0,1,4'b0000, 0,1));
    seq2.push_back(mk(0,1,0,0,0,1,4'b1000,15,1));
    seq2.push_back(mk(1,0,0,1,4'b1000,0,4'b1000,15,0));
    for (int k = 0; k < 3; k++) begin
      seq2.push_back(mk(1,1,1,0,0,1,4'b1000,15,0));
    end
    seq2.push_back(mk(1,1,0,0,0,0,4'b1001,14,0));
    seq2.push_back(mk(1,0,1,1,4'b0000,0,4'b0000,0,0));
    seq2.push_back(mk(1,1,0,0,0,1,4'b0000, 0,0));
    seq2.push_back(mk(1,1,1,0,0,0,4'b0001, 1,0));

    idle_all();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst count", 32'(ifa.count), 32'd0);
    chk("rst bin",   32'(ifa.bin),   32'd0);
    chk("rst wrap",  32'(ifa.wrap),  32'd0);
    chk("rst sat count", 32'(ifb.count), 32'd0);
    rst = 1'b1;

    foreach (seq1[i]) apply(seq1[i], i);

    // Asynchronous reset between edges while count = 0101.
    idle_all();
    chk("pre-arst count", 32'(ifa.count), 32'b0101);
    #3 rst = 1'b0;
    #1;
    chk("arst count", 32'(ifa.count), 32'd0);
    chk("arst bin",   32'(ifa.bin),   32'd0);
    chk("arst wrap",  32'(ifa.wrap),  32'd0);
    @(posedge clk);
    #1;
    chk("arst hold count", 32'(ifa.count), 32'd0);
    #3 rst = 1'b1;

    foreach (seq2[i]) apply(seq2[i], 100 + i);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
